// File: rtl/video_pkg.sv
// Shared video-timing types, default blanking lengths and small helpers for the raster sources.
package video_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLine,
    StHblk,
    StVblk
  } state_e;

  localparam int unsigned DefHblank = 16;
  localparam int unsigned DefVblank = 32;

  // Counter width that stays at least one bit for degenerate sizes of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] tp_pixel(input int unsigned x, input int unsigned y);
    return 8'(x + y);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter with line and frame terminal-count flags.
module raster_counter
  import video_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  localparam int unsigned XW = cnt_width(IMG_WIDTH),
  localparam int unsigned YW = cnt_width(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          line_last_o,
  output logic          frame_last_o
);

  localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (adv_i) begin
      if (x_q == XLast) begin
        x_d = '0;
        y_d = (y_q == YLast) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign line_last_o  = (x_q == XLast);
  assign frame_last_o = (x_q == XLast) && (y_q == YLast);

endmodule

// File: rtl/pixel_stream_source.sv
// Frame-memory raster reader emitting a qualified 8-bit pixel stream with sof/eol/done framing.
// Define TEST_PATTERN_EN to allow an internal (x + y) pattern selected by test_mode at start.
module pixel_stream_source
  import video_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned HBLANK     = DefHblank,
  parameter int unsigned VBLANK     = DefVblank,
  localparam int unsigned AddrW = cnt_width(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             test_mode,
  output logic             mem_rd_en,
  output logic [AddrW-1:0] mem_addr,
  input  logic [7:0]       mem_rd_data,
  output logic             data_en,
  output logic [7:0]       pixel_out,
  output logic             sof,
  output logic             eol,
  output logic             busy,
  output logic             done
);

  localparam int unsigned XW = cnt_width(IMG_WIDTH);
  localparam int unsigned YW = cnt_width(IMG_HEIGHT);
  localparam int unsigned BW = cnt_width((HBLANK > VBLANK) ? HBLANK : VBLANK);

  localparam logic [AddrW-1:0] AddrLast = AddrW'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [BW-1:0]    HLast    = BW'(HBLANK - 1);
  localparam logic [BW-1:0]    VLast    = BW'(VBLANK - 1);
  localparam logic [BW-1:0]    VPen     = BW'(VBLANK - 2);

  state_e           state_q;
  logic [BW-1:0]    blk_q;
  logic [AddrW-1:0] addr_q;
  logic             rd_en_q, busy_q, done_q, tp_q, last_line_q;

  logic [XW-1:0] x_w;
  logic [YW-1:0] y_w;
  logic          line_last, frame_last;
  logic          tp_sel;

`ifdef TEST_PATTERN_EN
  assign tp_sel = test_mode;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign tp_sel           = 1'b0;
`endif

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_raster (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       ((state_q == StIdle) && start),
    .adv_i       (state_q == StLine),
    .x_o         (x_w),
    .y_o         (y_w),
    .line_last_o (line_last),
    .frame_last_o(frame_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      blk_q       <= '0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tp_q        <= 1'b0;
      last_line_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLine;
            busy_q  <= 1'b1;
            rd_en_q <= ~tp_sel;
            addr_q  <= '0;
            tp_q    <= tp_sel;
          end
        end
        StLine: begin
          // Hold on the final address so the counter never wraps inside a frame.
          if (addr_q != AddrLast) addr_q <= addr_q + 1'b1;
          if (line_last) begin
            state_q     <= StHblk;
            rd_en_q     <= 1'b0;
            blk_q       <= '0;
            last_line_q <= frame_last;
          end
        end
        StHblk: begin
          if (blk_q == HLast) begin
            blk_q <= '0;
            if (last_line_q) begin
              state_q <= StVblk;
              // A single-cycle vertical blank is also the done cycle.
              if (VBLANK == 1) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end else begin
              state_q <= StLine;
              rd_en_q <= ~tp_q;
            end
          end else begin
            blk_q <= blk_q + 1'b1;
          end
        end
        StVblk: begin
          if (blk_q == VLast) begin
            state_q <= StIdle;
          end else begin
            blk_q <= blk_q + 1'b1;
            if (blk_q == VPen) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1 aligns with memory read data; stage 2 is the registered output.
  logic       v1_q, sof1_q, eol1_q;
  logic [7:0] tp_pix1_q;
  logic       data_en_q, sof_q, eol_q;
  logic [7:0] pixel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      tp_pix1_q <= '0;
      data_en_q <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      pixel_q   <= '0;
    end else begin
      v1_q      <= (state_q == StLine);
      sof1_q    <= (state_q == StLine) && (x_w == '0) && (y_w == '0);
      eol1_q    <= (state_q == StLine) && line_last;
      tp_pix1_q <= tp_pixel(32'(x_w), 32'(y_w));
      data_en_q <= v1_q;
      sof_q     <= v1_q & sof1_q;
      eol_q     <= v1_q & eol1_q;
      if (!v1_q)     pixel_q <= '0;
      else if (tp_q) pixel_q <= tp_pix1_q;
      else           pixel_q <= mem_rd_data;
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign data_en   = data_en_q;
  assign pixel_out = pixel_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Scoreboard bench for pixel_stream_source on a 4x3 frame with a memory returning its address.
module tb_pixel_stream_source;

  localparam int unsigned W         = 4;
  localparam int unsigned H         = 3;
  localparam int unsigned HB        = 2;
  localparam int unsigned VB        = 3;
  localparam int unsigned NPIX      = W * H;
  localparam int unsigned AW        = $clog2(NPIX);
  localparam int          FRAME_CYC = H * (W + HB) + VB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          test_mode = 1'b0;
  logic          mem_rd_en, data_en, sof, eol, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data = 8'h00;
  logic [7:0]    pixel_out;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t   sb[$];
  longint rd_t[$];
  int     checks = 0, errors = 0;
  longint cyc = 0;
  bit     sb_on = 1'b0, cur_tp = 1'b0, prev_de = 1'b0;
  int     rd_idx = 0, de_cnt = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0;
  int     stray = 0, tp_rd_cnt = 0, frames_exp = 0;
  longint last_de = -1;

  pixel_stream_source #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .HBLANK    (HB),
    .VBLANK    (VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .test_mode  (test_mode),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .data_en    (data_en),
    .pixel_out  (pixel_out),
    .sof        (sof),
    .eol        (eol),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory holds its own address; junk on non-read cycles exposes wrong latency.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? 8'(mem_addr) : 8'($urandom);

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (sb_on) begin
        if (mem_rd_en) begin
          if (cur_tp) tp_rd_cnt++;
          check_eq("rd_addr", longint'(mem_addr), rd_idx);
          rd_idx++;
          rd_t.push_back(cyc);
        end
        if (data_en) begin
          exp_t e;
          de_cnt++;
          if (sof) sof_cnt++;
          if (eol) eol_cnt++;
          if (sof && last_de >= 0)
            check_eq("frame_gap", longint'((cyc - last_de - 1) >= VB), 1);
          else if (!prev_de && last_de >= 0)
            check_eq("line_gap", longint'((cyc - last_de - 1) >= HB), 1);
          check_eq("sb_avail", longint'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("pixel", longint'(pixel_out), longint'(e.pix));
            check_eq("sof", longint'(sof), longint'(e.sof));
            check_eq("eol", longint'(eol), longint'(e.eol));
          end
          if (!cur_tp) begin
            check_eq("lat_avail", longint'(rd_t.size() != 0), 1);
            if (rd_t.size() != 0) check_eq("latency", cyc - rd_t.pop_front(), 2);
          end
          last_de = cyc;
        end else if (sof || eol) begin
          stray++;
        end
        prev_de = data_en;
      end
    end
  end

  task automatic do_frame(input bit tp, input int stray_at, input bit start_on_done);
    int  n, busy_low;
    bit  exp_tp;
    exp_t e;
`ifdef TEST_PATTERN_EN
    exp_tp = tp;
`else
    exp_tp = 1'b0;
`endif
    for (int i = 0; i < int'(NPIX); i++) begin
      int x, y;
      x     = i % W;
      y     = i / W;
      e.pix = exp_tp ? 8'(x + y) : 8'(i);
      e.sof = (i == 0);
      e.eol = (x == int'(W) - 1);
      sb.push_back(e);
    end
    cur_tp = exp_tp;
    rd_idx = 0;
    frames_exp++;
    @(posedge clk); #1;
    start     = 1'b1;
    test_mode = tp;
    @(posedge clk); #1;
    start     = 1'b0;
    test_mode = ~tp;
    check_eq("busy_rise", longint'(busy), 1);
    check_eq("first_addr", longint'(mem_addr), 0);
    check_eq("first_rd_en", longint'(mem_rd_en), longint'(!exp_tp));
    n        = 1;
    busy_low = 0;
    while (done !== 1'b1 && n < 4 * FRAME_CYC) begin
      if (busy !== 1'b1) busy_low++;
      start = (n == stray_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check_eq("done_cycle", n, FRAME_CYC);
    check_eq("busy_fall", longint'(busy), 0);
    check_eq("busy_hold", busy_low, 0);
    if (start_on_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("start_on_done_ign", longint'(busy), 0);
    end
    test_mode = 1'b0;
  endtask

  task automatic do_abort();
    sb_on = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check_eq("mid_line2_addr", longint'(mem_addr), W + 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_zero",
             longint'({mem_rd_en, mem_addr, data_en, pixel_out, sof, eol, busy, done}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    rd_t.delete();
    last_de = -1;
    prev_de = 1'b0;
    sb_on   = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_zero",
             longint'({mem_rd_en, mem_addr, data_en, pixel_out, sof, eol, busy, done}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_on = 1'b1;
    repeat (2) @(posedge clk);

    do_frame(1'b0, -1, 1'b0);
    repeat (3) @(posedge clk);
    do_frame(1'b0, 3, 1'b1);
    repeat (3) @(posedge clk);
    do_abort();
    do_frame(1'b0, -1, 1'b0);
    repeat (3) @(posedge clk);
    do_frame(1'b1, -1, 1'b0);
    repeat (3) @(posedge clk);
    do_frame(1'b0, -1, 1'b0);
    do_frame(1'b0, -1, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    check_eq("done_count", done_cnt, frames_exp);
    check_eq("data_en_count", de_cnt, NPIX * frames_exp);
    check_eq("eol_count", eol_cnt, H * frames_exp);
    check_eq("sof_count", sof_cnt, frames_exp);
    check_eq("stray_sof_eol", stray, 0);
    check_eq("tp_rd_en", tp_rd_cnt, 0);
    check_eq("sb_drained", longint'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 Parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame.
REQ-003 Parameter HBLANK, default 16, idle cycles after each line, minimum 1.
REQ-004 Parameter VBLANK, default 32, idle cycles after the last line's blanking, minimum 1.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to emit one frame.
REQ-008 test_mode  input  1  selects internal pattern; see Configuration.
REQ-009 mem_rd_en  output  1  frame-memory read strobe.
REQ-010 mem_addr  output  $clog2(IMG_WIDTH*IMG_HEIGHT)  read address, raster order.
REQ-011 mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en.
REQ-012 data_en  output  1  pixel valid, the stream qualifier consumed by the 3x3 filter blocks.
REQ-013 pixel_out  output  8  grey pixel.
REQ-014 sof  output  1  high with the first data_en of a frame.
REQ-015 eol  output  1  high with the last data_en of each line.
REQ-016 busy  output  1  high from the cycle after an accepted start until done.
REQ-017 done  output  1  one-cycle pulse at frame end.

Function
REQ-018 The FSM SHALL have states IDLE, LINE, HBLK, VBLK.
- IDLE→LINE on start.
- LINE→HBLK after IMG_WIDTH reads.
- HBLK→LINE after HBLANK cycles if more lines remain, else →VBLK.
- VBLK→IDLE after VBLANK cycles.
REQ-019 In LINE, mem_rd_en SHALL be high every cycle, with mem_addr incrementing by 1 from 0 at frame start to IMG_WIDTH*IMG_HEIGHT-1.
REQ-020 mem_addr SHALL return to 0 on every accepted start, with no wrap mid-frame.
REQ-021 pixel_out SHALL be registered from mem_rd_data, so data_en rises 2 cycles after the matching mem_rd_en; fixed latency 2.
REQ-022 sof and eol SHALL be delayed identically to data_en and SHALL be zero whenever data_en is zero.
REQ-023 Each frame SHALL produce exactly IMG_WIDTH*IMG_HEIGHT data_en cycles, IMG_HEIGHT eol pulses, and one sof pulse.
REQ-024 data_en SHALL be low for at least HBLANK cycles between lines, so each line is a contiguous burst.
REQ-025 done SHALL pulse on the last VBLK cycle, and busy SHALL fall in the same cycle.
REQ-026 start while busy SHALL be ignored, with no queuing.
REQ-027 start coincident with done SHALL be ignored.
REQ-028 Internal x/y counters SHALL be sized with $clog2 of IMG_WIDTH/IMG_HEIGHT.

Reset
REQ-029 On rst_n low, the FSM SHALL go to IDLE, counters to 0, and all outputs to 0, including pixel_out.
REQ-030 Reset mid-frame SHALL abort immediately, with no done pulse; the next start SHALL begin at address 0.

Configuration
REQ-031 With TEST_PATTERN_EN defined and test_mode high at start, the block SHALL:
- hold mem_rd_en low;
- output pixel_out = (x + y) mod 256 with identical timing and latency.
test_mode SHALL be sampled only at start.
REQ-032 Without TEST_PATTERN_EN, test_mode SHALL be ignored and the port kept; memory is always used.

Structure
REQ-033 The state encoding typedef and the default blanking constants SHALL reside in shared package video_pkg.
REQ-034 One sub-module, raster_counter (x/y counting with line and frame terminal-count flags), SHALL be instantiated; the FSM and output pipeline SHALL stay in the top level.

Verification
REQ-035 Cover the following directed scenarios:
- IMG_WIDTH=4, IMG_HEIGHT=3, HBLANK=2, VBLANK=3, memory holding addr value, one start → pixels 0..11 in order, 12 data_en, eol on 3/7/11, sof on 0, done once.
- Latency: mem_rd_en for addr 0 at cycle t → data_en with pixel 0x00 at t+2.
- start pulsed during LINE and on the done cycle → ignored; exactly one frame emitted, busy timing unchanged.
- rst_n low in the middle of line 2 → all outputs 0 the next cycle, no done; restart → first mem_addr = 0.
- TEST_PATTERN_EN defined, test_mode=1 → mem_rd_en never high, pixel at (x=3, y=2) = 5; undefined → memory data used.
- Back-to-back frames: start on the cycle after done → second frame identical, with ≥VBLANK idle cycles between frames.
